// File: rtl/seu_reader_pkg.sv
// seu_reader_pkg: shared constants and types for the SEU count reader.
package seu_reader_pkg;

  localparam int unsigned CountWidth  = 16;
  localparam logic [15:0] SatValue    = 16'hFFFF;
  // Cycles after the clear cycle during which a falling count is not a wrap
  localparam int unsigned WrapMaskLen = 2;

  typedef enum logic [1:0] {
    CmdRead      = 2'b00,
    CmdReadClear = 2'b01,
    CmdReadThr   = 2'b10,
    CmdWriteThr  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCapture = 3'd1,
    StClear   = 3'd2,
    StAck     = 3'd3,
    StWaitLow = 3'd4
  } state_e;

endpackage

// File: rtl/seu_wrap_detector.sv
// seu_wrap_detector: flags a counter wrap (count dropping below its previous
// value), ignoring the drop caused by our own clear pulse.
module seu_wrap_detector
  import seu_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  res,
  input  logic [CountWidth-1:0] count_i,
  input  logic                  clear_i,
  output logic                  ovf_o
);

  logic [CountWidth-1:0]  prev_q;
  logic [WrapMaskLen-1:0] mask_q;
  logic                   ovf_q;
  logic                   mask_active;
  logic                   wrap;

  // Mask covers the clear cycle itself plus the cycles while the counter zeroes
  assign mask_active = clear_i | (|mask_q);
  assign wrap        = (count_i < prev_q) & ~mask_active;
  assign ovf_o       = ovf_q;

  // Track previous count, age the mask, keep the sticky overflow (clear wins)
  always_ff @(posedge clk) begin
    if (res) begin
      prev_q <= '0;
      mask_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= count_i;
      mask_q <= (mask_q << 1) | WrapMaskLen'(clear_i);
      ovf_q  <= clear_i ? 1'b0 : (ovf_q | wrap);
    end
  end

endmodule

// File: rtl/seu_count_reader.sv
// seu_count_reader: four-phase command front end for a voted SEU counter.
// Threshold register and alarm compare exist only when SEU_READER_ALARM_EN
// is defined; otherwise alarm_o is 0 and threshold commands return 0.
module seu_count_reader
  import seu_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  res,
  input  logic [CountWidth-1:0] seu_count_i,
  output logic                  clear_o,
  input  logic                  req_i,
  input  logic [1:0]            cmd_i,
  input  logic [CountWidth-1:0] wdata_i,
  output logic                  ack_o,
  output logic [CountWidth-1:0] rdata_o,
  output logic                  ovf_o,
  output logic                  lost_o,
  output logic                  alarm_o
);

  state_e                state_q;
  cmd_e                  cmd;
  logic                  clear_q;
  logic                  ack_q;
  logic                  lost_q;
  logic [CountWidth-1:0] snap_q;
  logic [CountWidth-1:0] raw_q;    // unsaturated count seen at capture
  logic [CountWidth-1:0] rdata_q;
  logic [CountWidth-1:0] capture_val;
  logic [CountWidth-1:0] thr_val;
  logic [CountWidth-1:0] wr_val;

  assign cmd     = cmd_e'(cmd_i);
  assign clear_o = clear_q;
  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign lost_o  = lost_q;

  seu_wrap_detector u_wrap (
    .clk     (clk),
    .res     (res),
    .count_i (seu_count_i),
    .clear_i (state_q == StClear),
    .ovf_o   (ovf_o)
  );

`ifdef SEU_READER_ALARM_EN
  logic [CountWidth-1:0] thr_q;
  logic                  alarm_q;

  assign thr_val = thr_q;
  assign wr_val  = wdata_i;
  assign alarm_o = alarm_q;

  // Threshold register, written in the capture cycle of WRITE_THRESHOLD
  always_ff @(posedge clk) begin
    if (res) begin
      thr_q <= '0;
    end else if (state_q == StCapture && cmd == CmdWriteThr) begin
      thr_q <= wdata_i;
    end
  end

  // Sticky alarm; a zero threshold disables the compare, clear cycle wins
  always_ff @(posedge clk) begin
    if (res) begin
      alarm_q <= 1'b0;
    end else if (state_q == StClear) begin
      alarm_q <= 1'b0;
    end else if (((thr_q != '0) && (seu_count_i >= thr_q)) || ovf_o) begin
      alarm_q <= 1'b1;
    end
  end
`else
  logic unused_wdata;

  assign unused_wdata = ^wdata_i;
  assign thr_val      = '0;
  assign wr_val       = '0;
  assign alarm_o      = 1'b0;
`endif

  // Value loaded into the snapshot during the capture cycle
  always_comb begin
    capture_val = '0;
    unique case (cmd)
      CmdRead, CmdReadClear: capture_val = ovf_o ? SatValue : seu_count_i;
      CmdReadThr:            capture_val = thr_val;
      CmdWriteThr:           capture_val = wr_val;
    endcase
  end

  // Command sequencer with registered clear/ack/rdata and the lost flag
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= StIdle;
      clear_q <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      snap_q  <= '0;
      raw_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      clear_q <= 1'b0;
      ack_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_i) state_q <= StCapture;
        end
        StCapture: begin
          snap_q <= capture_val;
          if (cmd == CmdRead || cmd == CmdReadClear) raw_q <= seu_count_i;
          if (cmd == CmdReadClear) begin
            lost_q  <= 1'b0;
            clear_q <= 1'b1;
            state_q <= StClear;
          end else begin
            ack_q   <= 1'b1;
            rdata_q <= capture_val;
            state_q <= StAck;
          end
        end
        StClear: begin
          // Any increment between snapshot and clear is lost by the clear
          if (seu_count_i != raw_q) lost_q <= 1'b1;
          ack_q   <= 1'b1;
          rdata_q <= snap_q;
          state_q <= StAck;
        end
        StAck: begin
          state_q <= StWaitLow;
        end
        StWaitLow: begin
          if (!req_i) state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seu_count_reader.sv
// tb_seu_count_reader: directed and randomized checks of seu_count_reader
// against a cycle-timeline reference model. Honors SEU_READER_ALARM_EN.
module tb_seu_count_reader;

  logic        clk = 1'b0;
  logic        res;
  logic [15:0] seu_count_i;
  logic        clear_o;
  logic        req_i;
  logic [1:0]  cmd_i;
  logic [15:0] wdata_i;
  logic        ack_o;
  logic [15:0] rdata_o;
  logic        ovf_o;
  logic        lost_o;
  logic        alarm_o;

`ifdef SEU_READER_ALARM_EN
  localparam bit AlarmEn = 1'b1;
`else
  localparam bit AlarmEn = 1'b0;
`endif

  seu_count_reader dut (
    .clk         (clk),
    .res         (res),
    .seu_count_i (seu_count_i),
    .clear_o     (clear_o),
    .req_i       (req_i),
    .cmd_i       (cmd_i),
    .wdata_i     (wdata_i),
    .ack_o       (ack_o),
    .rdata_o     (rdata_o),
    .ovf_o       (ovf_o),
    .lost_o      (lost_o),
    .alarm_o     (alarm_o)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  int          k = 0;
  logic [15:0] cnt = 16'd0;
  int          inc_pct = 0;
  bit          bump_clear = 1'b0;
  bit          clr_prev = 1'b0;

  // Reference model: command timeline plus sticky flags
  bit          m_busy;
  int          m_cap, m_clr, m_ack, m_last_clr;
  logic [1:0]  m_cmd;
  logic [15:0] m_wd, m_prev, m_snap, m_raw, m_thr, m_rdata;
  bit          m_ovf, m_lost, m_alarm;

  function automatic void model_reset();
    m_busy = 1'b0; m_cap = -1; m_clr = -1; m_ack = -1; m_last_clr = -100;
    m_cmd = 2'b00; m_wd = 16'h0; m_prev = 16'h0; m_snap = 16'h0; m_raw = 16'h0;
    m_thr = 16'h0; m_rdata = 16'h0; m_ovf = 1'b0; m_lost = 1'b0; m_alarm = 1'b0;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, k, got, exp);
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model
  task automatic step(input bit rs, input bit rq, input logic [1:0] c,
                      input logic [15:0] wd, output bit ga, output logic [15:0] grd);
    bit          exp_ack, exp_clr, mask, wrap, acond, n_ovf, n_alarm, n_lost;
    logic [15:0] exp_rd;
    exp_ack = m_busy && (k == m_ack);
    exp_clr = m_busy && (k == m_clr);
    exp_rd  = exp_ack ? m_snap : m_rdata;
    // Emulated SEU counter: zeroes after a clear pulse
    if (clr_prev) cnt = 16'd0;
    else if (exp_clr && bump_clear) cnt = cnt + 16'd1;
    else if (inc_pct > 0 && int'($urandom_range(0, 99)) < inc_pct) cnt = cnt + 16'd1;
    res = rs; req_i = rq; cmd_i = c; wdata_i = wd; seu_count_i = cnt;
    ga  = ack_o;
    grd = rdata_o;
    check("ack", int'(ack_o), int'(exp_ack));
    check("clear", int'(clear_o), int'(exp_clr));
    check("rdata", int'(rdata_o), int'(exp_rd));
    check("ovf", int'(ovf_o), int'(m_ovf));
    check("lost", int'(lost_o), int'(m_lost));
    check("alarm", int'(alarm_o), int'(m_alarm));
    clr_prev = exp_clr;
    if (rs) begin
      model_reset();
    end else begin
      if (exp_clr) m_last_clr = k;
      mask    = (k >= m_last_clr) && (k <= m_last_clr + 2);
      wrap    = (cnt < m_prev) && !mask;
      acond   = AlarmEn && (((m_thr != 16'h0) && (cnt >= m_thr)) || m_ovf);
      n_ovf   = exp_clr ? 1'b0 : (m_ovf || wrap);
      n_alarm = exp_clr ? 1'b0 : (m_alarm || acond);
      n_lost  = m_lost;
      if (m_busy && k == m_cap) begin
        case (m_cmd)
          2'b00, 2'b01: begin
            m_snap = m_ovf ? 16'hFFFF : cnt;
            m_raw  = cnt;
            if (m_cmd == 2'b01) n_lost = 1'b0;
          end
          2'b10: m_snap = m_thr;
          default: begin
            if (AlarmEn) m_thr = m_wd;
            m_snap = AlarmEn ? m_wd : 16'h0;
          end
        endcase
      end
      if (exp_clr && cnt != m_raw) n_lost = 1'b1;
      if (exp_ack) m_rdata = m_snap;
      if (!m_busy) begin
        if (rq) begin
          m_busy = 1'b1; m_cmd = c; m_wd = wd; m_cap = k + 1;
          m_clr  = (c == 2'b01) ? k + 2 : -1;
          m_ack  = (c == 2'b01) ? k + 3 : k + 2;
        end
      end else if (k > m_ack && !rq) begin
        m_busy = 1'b0;
      end
      m_prev = cnt; m_ovf = n_ovf; m_alarm = n_alarm; m_lost = n_lost;
    end
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic idle(input int n);
    bit          ga;
    logic [15:0] grd;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, 16'h0, ga, grd);
  endtask

  // Full handshake; checks latency and returns the acknowledged data
  task automatic do_cmd(input logic [1:0] c, input logic [15:0] wd, input bit early,
                        output logic [15:0] rd);
    bit          ga;
    logic [15:0] grd;
    int          seen;
    seen = -1;
    rd   = 16'h0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, !(early && i > 0), c, wd, ga, grd);
      if (ga) begin
        seen = i;
        rd   = grd;
        break;
      end
    end
    check("latency", seen, (c == 2'b01) ? 3 : 2);
    if (!early) step(1'b0, 1'b1, c, wd, ga, grd);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, c, wd, ga, grd);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d", k);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] rd;
    logic [1:0]  c;
    logic [15:0] wd;
    bit          ga;
    logic [15:0] grd;

    res = 1'b1; req_i = 1'b0; cmd_i = 2'b00; wdata_i = 16'h0; seu_count_i = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_rdata", int'(rdata_o), 0);
    check("rst_ack", int'(ack_o), 0);

    // Plain read
    cnt = 16'd5;
    do_cmd(2'b00, 16'h0, 1'b0, rd);
    check("read5", int'(rd), 5);

    // Read and clear; zeroing must not look like a wrap
    cnt = 16'd9;
    do_cmd(2'b01, 16'h0, 1'b0, rd);
    check("rac9", int'(rd), 9);
    idle(2);
    check("no_ovf_after_clear", int'(ovf_o), 0);

    // Counter wraps on its own
    cnt = 16'hFFFF;
    idle(2);
    cnt = 16'h0000;
    idle(3);
    check("wrap_ovf", int'(ovf_o), 1);
    check("wrap_alarm", int'(alarm_o), int'(AlarmEn));
    do_cmd(2'b00, 16'h0, 1'b0, rd);
    check("read_sat", int'(rd), 16'hFFFF);
    do_cmd(2'b01, 16'h0, 1'b0, rd);
    check("rac_sat", int'(rd), 16'hFFFF);
    idle(1);
    check("ovf_cleared", int'(ovf_o), 0);
    check("alarm_cleared", int'(alarm_o), 0);

    // Threshold write and ramp
    do_cmd(2'b11, 16'd3, 1'b0, rd);
    check("wthr_echo", int'(rd), AlarmEn ? 3 : 0);
    cnt = 16'd1; idle(1);
    cnt = 16'd2; idle(1);
    check("alarm_below", int'(alarm_o), 0);
    cnt = 16'd3; idle(1);
    check("alarm_at3", int'(alarm_o), int'(AlarmEn));
    do_cmd(2'b10, 16'h0, 1'b0, rd);
    check("rthr", int'(rd), AlarmEn ? 3 : 0);

    // Increment lands in the clear cycle
    cnt = 16'd7;
    bump_clear = 1'b1;
    do_cmd(2'b01, 16'h0, 1'b0, rd);
    bump_clear = 1'b0;
    check("lost_rdata", int'(rd), 7);
    check("lost_flag", int'(lost_o), 1);

    // Reset during the clear cycle drops the command
    cnt = 16'd10; idle(1);
    cnt = 16'd2;  idle(2);
    bump_clear = 1'b1;
    step(1'b0, 1'b1, 2'b01, 16'h0, ga, grd);
    step(1'b0, 1'b1, 2'b01, 16'h0, ga, grd);
    check("clr_before_rst", int'(clear_o), 1);
    step(1'b1, 1'b1, 2'b01, 16'h0, ga, grd);
    bump_clear = 1'b0;
    check("rst_clear_o", int'(clear_o), 0);
    check("rst_flags", int'({ovf_o, lost_o, alarm_o}), 0);
    idle(4);
    cnt = 16'd4;
    do_cmd(2'b00, 16'h0, 1'b0, rd);
    check("read_after_rst", int'(rd), 4);

    // Request dropped before acknowledge still completes
    do_cmd(2'b01, 16'h0, 1'b1, rd);
    check("early_drop_rd", int'(rd), 4);

    // Randomized command mix
    for (int t = 0; t < 60; t++) begin
      c       = 2'($urandom_range(0, 3));
      wd      = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(1, 40));
      inc_pct = int'($urandom_range(0, 60));
      if ($urandom_range(0, 7) == 0) cnt = 16'($urandom_range(16'hFFF8, 16'hFFFF));
      do_cmd(c, wd, $urandom_range(0, 5) == 0, rd);
      idle(int'($urandom_range(0, 2)));
    end
    inc_pct = 0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
